request_arbiter_8: RTL and testbench

Registered 8-channel request capture and round-robin arbiter. Detects rising edges on eight request lines, holds them as pending, and issues one registered one-hot grant at a time under a valid/ack handshake. `grant` feeds the downstream 8-to-3 encoder directly; it is always all-zeros or exactly one-hot, so the encoder always sees a legal input.

---
 rtl/request_arbiter_8_if.sv | 21 ++
 rtl/request_arbiter_8.sv | 124 ++++++++++++
 tb/tb_request_arbiter_8.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/request_arbiter_8_if.sv
// Handshake/bus bundle between the request arbiter and its consumer.
// The master drives requests, masks and acks; the slave returns grant and status.
interface request_arbiter_8_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       grant_ack;
    logic [7:0] grant;
    logic       grant_valid;
    logic [7:0] pending;
    logic       overflow;

    modport master (
        output req, mask, grant_ack,
        input  grant, grant_valid, pending, overflow
    );

    modport slave (
        input  req, mask, grant_ack,
        output grant, grant_valid, pending, overflow
    );
endinterface

// File: rtl/request_arbiter_8.sv
// 8-channel rising-edge request capture with a round-robin, one-hot,
// registered grant under a valid/ack handshake.
module request_arbiter_8 (
    input  logic                clk,
    input  logic                rst_n,
    request_arbiter_8_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] req_q;
    logic [7:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gidx_q, gidx_d;
    logic [7:0] grant_q, grant_d;
    logic       grant_valid_q, grant_valid_d;

    logic [7:0] rise_s;
    logic [7:0] clr_s;
    logic [3:0] pick_s;
    logic       win_found_s;
    logic [2:0] win_idx_s;

    // Returns {found, index} of the first eligible channel at or after ptr.
    function automatic logic [3:0] pick_winner(input logic [7:0] elig, input logic [2:0] ptr);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Edge detection, pending bookkeeping and sticky overflow.
    always_comb begin
        rise_s = bus.req & ~req_q;
        if ((state_q == ST_GRANT) && bus.grant_ack) begin
            clr_s = grant_q;
        end else begin
            clr_s = 8'h00;
        end
        pending_d   = (pending_q & ~clr_s) | rise_s;
        overflow_d  = overflow_q | (|(rise_s & pending_q & ~clr_s));
        pick_s      = pick_winner(pending_q & ~bus.mask, ptr_q);
        win_found_s = pick_s[3];
        win_idx_s   = pick_s[2:0];
    end

    // Grant FSM: issue in IDLE, hold in GRANT until ack.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_d       = 8'h01 << win_idx_s;
                    grant_valid_d = 1'b1;
                    gidx_d        = win_idx_s;
                    state_d       = ST_GRANT;
                end else begin
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (bus.grant_ack) begin
                    ptr_d         = gidx_q + 3'd1;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d       = ST_GRANT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = 8'h00;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= 8'h00;
            pending_q     <= 8'h00;
            overflow_q    <= 1'b0;
            ptr_q         <= 3'd0;
            gidx_q        <= 3'd0;
            grant_q       <= 8'h00;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= bus.req;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.pending     = pending_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_request_arbiter_8.sv
// Scoreboard bench for request_arbiter_8: directed scenarios followed by
// random traffic, checked against a channel-level reference model.
module tb_request_arbiter_8;
    logic clk;
    logic rst_n;
    request_arbiter_8_if bus ();

    request_arbiter_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [7:0]   m_pend;
    bit [7:0]   m_req_prev;
    bit         m_ovf;
    bit         m_busy;
    int         m_ptr;
    int         m_gidx;
    logic [7:0] exp_q[$];
    bit         stim_done = 1'b0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model, evaluated on the inputs about to be sampled.
    task automatic model_step(input bit [7:0] r, input bit [7:0] m, input bit a, input bit rstn);
        bit [7:0] old;
        bit [7:0] clr;
        bit [7:0] rise;
        bit       found;
        int       idx;
        if (!rstn) begin
            m_pend = 8'h00; m_req_prev = 8'h00; m_ovf = 1'b0;
            m_busy = 1'b0;  m_ptr = 0;          m_gidx = 0;
        end else begin
            old   = m_pend;
            clr   = 8'h00;
            rise  = r & ~m_req_prev;
            found = 1'b0;
            if (m_busy) begin
                if (a) begin
                    clr[m_gidx] = 1'b1;
                    m_ptr  = (m_gidx + 1) % 8;
                    m_busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < 8; i++) begin
                    idx = (m_ptr + i) % 8;
                    if (!found && old[idx] && !m[idx]) begin
                        found  = 1'b1;
                        m_busy = 1'b1;
                        m_gidx = idx;
                        exp_q.push_back(8'(1 << idx));
                    end
                end
            end
            for (int b = 0; b < 8; b++) begin
                if (rise[b] && old[b] && !clr[b]) m_ovf = 1'b1;
                m_pend[b] = (old[b] && !clr[b]) || rise[b];
            end
            m_req_prev = r;
        end
    endtask

    task automatic cyc(input bit [7:0] r, input bit [7:0] m, input bit a, input bit rstn);
        @(negedge clk);
        bus.req       = r;
        bus.mask      = m;
        bus.grant_ack = a;
        rst_n         = rstn;
        model_step(r, m, a, rstn);
    endtask

    // Monitor: compares status every cycle and pops expected grants as they appear.
    logic [7:0] held;
    bit         prev_gv;
    initial begin
        held    = 8'h00;
        prev_gv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!stim_done) begin
                check8("grant_valid", {7'b0, bus.grant_valid}, {7'b0, m_busy});
                check8("pending", bus.pending, m_pend);
                check8("overflow", {7'b0, bus.overflow}, {7'b0, m_ovf});
                if (bus.grant_valid && !prev_gv) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got %h expected none at %0t", bus.grant, $time);
                    end else begin
                        held = exp_q.pop_front();
                        check8("grant_new", bus.grant, held);
                    end
                end else if (bus.grant_valid) begin
                    check8("grant_hold", bus.grant, held);
                end else begin
                    check8("grant_idle", bus.grant, 8'h00);
                end
                prev_gv = bus.grant_valid;
            end
        end
    end

    bit [7:0] r_cur;
    bit [7:0] m_cur;

    initial begin
        bus.req = 8'h00; bus.mask = 8'h00; bus.grant_ack = 1'b0; rst_n = 1'b0;
        model_step(8'h00, 8'h00, 1'b0, 1'b0);

        // Reset and idle
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // Single request on channel 5, then ack
        cyc(8'h20, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // Reset to bring ptr back to 0, then all channels at once with ack held
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        cyc(8'hFF, 8'h00, 1'b1, 1'b1);
        repeat (18) cyc(8'hFF, 8'h00, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h01, 8'h00, 1'b0, 1'b1);
        repeat (3) cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b1, 1'b1);

        // Masking: pending 0C with everything masked, then mask 04, swap mask mid-grant
        cyc(8'h0C, 8'hFF, 1'b0, 1'b1);
        repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'h04, 1'b0, 1'b1);
        cyc(8'h00, 8'h04, 1'b0, 1'b1);
        repeat (3) cyc(8'h00, 8'h08, 1'b0, 1'b1);
        cyc(8'h00, 8'h08, 1'b1, 1'b1);
        repeat (3) cyc(8'h00, 8'h08, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // Overflow: channel 2 masked and pending, second rise
        cyc(8'h04, 8'h04, 1'b0, 1'b1);
        cyc(8'h00, 8'h04, 1'b0, 1'b1);
        cyc(8'h04, 8'h04, 1'b0, 1'b1);
        repeat (3) cyc(8'h00, 8'h04, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);

        // Rise on the granted bit in the ack cycle: re-pending without overflow
        cyc(8'h02, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h02, 8'h00, 1'b1, 1'b1);
        repeat (2) cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // Reset mid-grant with req[4] held through release
        cyc(8'h10, 8'h00, 1'b0, 1'b1);
        repeat (3) cyc(8'h10, 8'h00, 1'b0, 1'b1);
        cyc(8'h10, 8'h00, 1'b0, 1'b0);
        repeat (4) cyc(8'h10, 8'h00, 1'b0, 1'b1);
        cyc(8'h10, 8'h00, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // Random traffic
        r_cur = 8'h00;
        m_cur = 8'h00;
        for (int t = 0; t < 600; t++) begin
            r_cur = r_cur ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) m_cur = 8'($urandom & $urandom);
            cyc(r_cur, m_cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0));
        end

        // Drain
        m_cur = 8'h00;
        repeat (4) cyc(8'h00, 8'h00, 1'b1, 1'b1);
        repeat (2) cyc(8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        stim_done = 1'b1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
